scan_test_ctrl: RTL

SCAN_TEST_CTRL -- requirements
Module: scan_test_ctrl

---
 rtl/scan_pkg.sv | 8 +
 rtl/scan_shift_reg.sv | 17 +
 rtl/scan_test_ctrl.sv | 96 +++++++++
 3 files changed

// File: rtl/scan_pkg.sv
// scan_pkg: shared state encoding, fail counter limit and counter sizing for the scan test controller
package scan_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, CAPTURE, UNLOAD, REPORT, DONE} state_t;
  localparam int FAIL_CNT_MAX = 255;
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/scan_shift_reg.sv
// scan_shift_reg: parallel-load register shifting right, serial input entering at the MSB
module scan_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clear_n,
  input  logic         load,
  input  logic         shift,
  input  logic         ser_in,
  input  logic [W-1:0] load_data,
  output logic [W-1:0] q
);
  logic [W-1:0] data_q, data_d;
  always_comb data_d = load ? load_data : shift ? {ser_in, data_q[W-1:1]} : data_q;
  always_ff @(posedge clk) data_q <= !clear_n ? '0 : data_d;
  assign q = data_q;
endmodule

// File: rtl/scan_test_ctrl.sv
// scan_test_ctrl: scan test session sequencer; shifts each pattern in LSB first, captures,
// unloads the response and compares it against the latched expectation
module scan_test_ctrl
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN = 8
) (
  input  logic                 clk,
  input  logic                 clear_n,
  input  logic                 start,
  input  logic                 pat_valid,
  output logic                 pat_ready,
  input  logic [CHAIN_LEN-1:0] pat_data,
  input  logic [CHAIN_LEN-1:0] pat_expect,
  input  logic                 pat_last,
  output logic                 scan_en,
  output logic                 scan_in,
  input  logic                 scan_out,
  output logic                 cap_en,
  output logic                 chain_clear,
  output logic                 resp_valid,
  output logic [CHAIN_LEN-1:0] resp_data,
  output logic                 resp_fail,
  output logic [7:0]           fail_count,
  output logic                 busy,
  output logic                 done
);
  localparam int CW = cnt_width(CHAIN_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(CHAIN_LEN - 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] fail_q, fail_d;
  logic [CHAIN_LEN-1:0] exp_q, exp_d, hold_q, hold_d, stim_q, rx_q;
  logic last_q, last_d, accept, cnt_end, in_report, mismatch, stim_unused;
  assign accept = state_q == LOAD && pat_valid;
  assign cnt_end = cnt_q == CNT_LAST;
  assign in_report = state_q == REPORT;
  assign mismatch = rx_q != exp_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    if (pat_valid) state_d = SHIFT;
      SHIFT:   if (cnt_end) state_d = CAPTURE;
      CAPTURE: state_d = UNLOAD;
      UNLOAD:  if (cnt_end) state_d = REPORT;
      REPORT:  state_d = last_q ? DONE : LOAD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cnt_d = ((state_q == SHIFT || state_q == UNLOAD) && !cnt_end) ? cnt_q + 1'b1 : '0;
    fail_d = (state_q == IDLE && start) ? '0 :
             (in_report && mismatch && fail_q != 8'(FAIL_CNT_MAX)) ? fail_q + 1'b1 : fail_q;
    exp_d = accept ? pat_expect : exp_q;
    last_d = accept ? pat_last : last_q;
    hold_d = in_report ? rx_q : hold_q;
  end
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      fail_q <= '0;
      exp_q <= '0;
      hold_q <= '0;
      last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      fail_q <= fail_d;
      exp_q <= exp_d;
      hold_q <= hold_d;
      last_q <= last_d;
    end
  end
  scan_shift_reg #(.W(CHAIN_LEN)) u_stim (
    .clk(clk), .clear_n(clear_n), .load(accept), .shift(state_q == SHIFT),
    .ser_in(1'b0), .load_data(pat_data), .q(stim_q)
  );
  scan_shift_reg #(.W(CHAIN_LEN)) u_resp (
    .clk(clk), .clear_n(clear_n), .load(1'b0), .shift(state_q == UNLOAD),
    .ser_in(scan_out), .load_data('0), .q(rx_q)
  );
  // only the LSB of the stimulus register drives the chain
  assign stim_unused = ^stim_q[CHAIN_LEN-1:1];
  assign pat_ready = state_q == LOAD;
  assign scan_en = state_q == SHIFT || state_q == UNLOAD;
  assign scan_in = state_q == SHIFT && stim_q[0];
  assign cap_en = state_q == CAPTURE;
  assign chain_clear = clear_n && state_q == IDLE && start;
  assign resp_valid = in_report;
  assign resp_data = in_report ? rx_q : hold_q;
  assign resp_fail = in_report && mismatch;
  assign fail_count = fail_q;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
endmodule
